// File: rtl/uart_receiver_if.sv
// rtl/uart_receiver_if.sv - RX line, frame configuration and received-word bundle for uart_receiver
interface uart_receiver_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  serial_data_in;
  logic                  parity_type;
  logic                  parity_enable;
  logic [DATA_WIDTH-1:0] parallel_data;
  logic                  data_valid;
  logic                  parity_error;
  logic                  framing_error;
  logic                  busy;

  modport master (
    input  serial_data_in, parity_type, parity_enable,
    output parallel_data, data_valid, parity_error, framing_error, busy
  );

  modport slave (
    output serial_data_in, parity_type, parity_enable,
    input  parallel_data, data_valid, parity_error, framing_error, busy
  );
endinterface

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - oversampling UART receiver; define UART_RX_MAJORITY_VOTE_EN for 2-of-3 bit voting
module uart_receiver #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic clk,
  input  logic reset,
  uart_receiver_if.master rx_if
);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(PRESCALE / 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q;
  logic [1:0]            sync_q;
  logic [CW-1:0]         cnt_q;
  logic [BW-1:0]         bit_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_type_q;
  logic                  par_en_q;
  logic                  par_err_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  dv_q;
  logic                  perr_q;
  logic                  ferr_q;
  logic                  busy_q;
  logic                  rx_s;
  logic                  bit_val;

  assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_VOTE_EN
  // Samples at MID-1 and MID are held; the vote completes one clock later with the live sample.
  localparam logic [CW-1:0] CNT_DEC = CNT_MID + CW'(1);
  logic [1:0] vote_q;
  assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);
`else
  localparam logic [CW-1:0] CNT_DEC = CNT_MID;
  assign bit_val = rx_s;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      sync_q     <= 2'b11;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_type_q <= 1'b0;
      par_en_q   <= 1'b0;
      par_err_q  <= 1'b0;
      data_out_q <= '0;
      dv_q       <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
      vote_q     <= 2'b00;
`endif
    end else begin
      sync_q <= {sync_q[0], rx_if.serial_data_in};
      dv_q   <= 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
      if (cnt_q == CNT_MID - CW'(1)) vote_q[0] <= rx_s;
      if (cnt_q == CNT_MID)          vote_q[1] <= rx_s;
`endif
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q    <= START;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            busy_q     <= 1'b1;
            par_type_q <= rx_if.parity_type;
            par_en_q   <= rx_if.parity_enable;
          end
        end
        START: begin
          if (cnt_q == CNT_DEC && bit_val) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= DATA;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (cnt_q == CNT_DEC) shift_q[bit_cnt_q] <= bit_val;
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_q <= '0;
              state_q   <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + BW'(1);
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        PARITY: begin
          // Even: bit should equal ^data; odd flips the expectation.
          if (cnt_q == CNT_DEC) par_err_q <= bit_val ^ (^shift_q) ^ par_type_q;
          if (cnt_q == CNT_LAST) begin
            state_q <= STOP;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          // Leave at the decision point so the next start bit has half a bit of margin.
          if (cnt_q == CNT_DEC) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            dv_q       <= 1'b1;
            data_out_q <= shift_q;
            perr_q     <= par_en_q & par_err_q;
            ferr_q     <= ~bit_val;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_if.parallel_data = data_out_q;
  assign rx_if.data_valid    = dv_q;
  assign rx_if.parity_error  = perr_q;
  assign rx_if.framing_error = ferr_q;
  assign rx_if.busy          = busy_q;
endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed self-checking bench for uart_receiver
module tb_uart_receiver;
  logic clk;
  logic reset;

  uart_receiver_if #(.DATA_WIDTH(8)) rx_if ();

  uart_receiver #(.DATA_WIDTH(8), .PRESCALE(8)) dut (
    .clk   (clk),
    .reset (reset),
    .rx_if (rx_if)
  );

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int MV = 1;
`else
  localparam int MV = 0;
`endif
  localparam int LAT_P  = 85 + MV;
  localparam int LAT_NP = 77 + MV;
  localparam int SYNC   = 3;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int dv_cnt  = 0;
  int busy_seen = 0;
  int   dv_cyc  [64];
  logic [7:0] dv_data [64];
  logic dv_perr [64];
  logic dv_ferr [64];
  logic dv_busy [64];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_if.busy) busy_seen = 1;
    if (rx_if.data_valid) begin
      dv_cyc[dv_cnt % 64]  = cyc;
      dv_data[dv_cnt % 64] = rx_if.parallel_data;
      dv_perr[dv_cnt % 64] = rx_if.parity_error;
      dv_ferr[dv_cnt % 64] = rx_if.framing_error;
      dv_busy[dv_cnt % 64] = rx_if.busy;
      dv_cnt = dv_cnt + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx_if.serial_data_in = b;
    idle(8);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pb,
                            input logic sb, output int c0);
    c0 = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (pe) send_bit(pb);
    send_bit(sb);
    rx_if.serial_data_in = 1'b1;
  endtask

  task automatic wait_dv(input string tag, input int target);
    int n = 0;
    while (dv_cnt < target && n < 200) begin
      idle(1);
      n++;
    end
    check_eq(tag, 32'(dv_cnt >= target), 32'd1);
  endtask

  task automatic check_frame(input string tag, input int idx, input logic [7:0] d,
                             input logic pe_exp, input logic fe_exp);
    check_eq({tag, "_data"}, 32'(dv_data[idx % 64]), 32'(d));
    check_eq({tag, "_perr"}, 32'(dv_perr[idx % 64]), 32'(pe_exp));
    check_eq({tag, "_ferr"}, 32'(dv_ferr[idx % 64]), 32'(fe_exp));
    check_eq({tag, "_busy"}, 32'(dv_busy[idx % 64]), 32'd0);
  endtask

  initial begin
    int c0;
    int c1;
    int base;
    reset = 1'b0;
    rx_if.serial_data_in = 1'b1;
    rx_if.parity_type    = 1'b0;
    rx_if.parity_enable  = 1'b0;
    idle(3);
    check_eq("rst_data", 32'(rx_if.parallel_data), 32'd0);
    check_eq("rst_dv",   32'(rx_if.data_valid), 32'd0);
    check_eq("rst_perr", 32'(rx_if.parity_error), 32'd0);
    check_eq("rst_ferr", 32'(rx_if.framing_error), 32'd0);
    check_eq("rst_busy", 32'(rx_if.busy), 32'd0);
    reset = 1'b1;
    idle(4);

    // 0xE6 even parity, parity bit 1
    rx_if.parity_type = 1'b0; rx_if.parity_enable = 1'b1;
    base = dv_cnt;
    send_frame(8'hE6, 1'b1, 1'b1, 1'b1, c0);
    wait_dv("e6_dv", base + 1);
    idle(16);
    check_eq("e6_count", 32'(dv_cnt), 32'(base + 1));
    check_frame("e6", base, 8'hE6, 1'b0, 1'b0);
    check_eq("e6_latency", 32'(dv_cyc[base % 64]), 32'(c0 + SYNC + LAT_P));

    // 0xFF odd parity: bit 1 correct, then bit 0 wrong
    rx_if.parity_type = 1'b1;
    base = dv_cnt;
    send_frame(8'hFF, 1'b1, 1'b1, 1'b1, c0);
    wait_dv("ff_ok_dv", base + 1);
    idle(16);
    check_frame("ff_ok", base, 8'hFF, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0, 1'b1, c0);
    wait_dv("ff_bad_dv", base + 2);
    idle(16);
    check_eq("ff_count", 32'(dv_cnt), 32'(base + 2));
    check_frame("ff_bad", base + 1, 8'hFF, 1'b1, 1'b0);

    // 0xF4 without parity; parity_type left at 1 must not matter
    rx_if.parity_enable = 1'b0;
    base = dv_cnt;
    send_frame(8'hF4, 1'b0, 1'b0, 1'b1, c0);
    wait_dv("f4_dv", base + 1);
    idle(16);
    check_frame("f4", base, 8'hF4, 1'b0, 1'b0);
    check_eq("f4_latency", 32'(dv_cyc[base % 64]), 32'(c0 + SYNC + LAT_NP));

    // 0x5A with stop bit 0
    base = dv_cnt;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, c0);
    wait_dv("5a_dv", base + 1);
    idle(24);
    check_eq("5a_count", 32'(dv_cnt), 32'(base + 1));
    check_frame("5a", base, 8'h5A, 1'b0, 1'b1);

    // 3-clock glitch on idle line
    base = dv_cnt;
    busy_seen = 0;
    rx_if.serial_data_in = 1'b0;
    idle(3);
    rx_if.serial_data_in = 1'b1;
    idle(8);
    check_eq("glitch_busy_seen", 32'(busy_seen), 32'd1);
    check_eq("glitch_busy_low", 32'(rx_if.busy), 32'd0);
    idle(16);
    check_eq("glitch_no_dv", 32'(dv_cnt), 32'(base));

    // back-to-back 0x01 then 0x80
    base = dv_cnt;
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, c0);
    send_frame(8'h80, 1'b0, 1'b0, 1'b1, c1);
    wait_dv("b2b_dv", base + 2);
    idle(16);
    check_eq("b2b_count", 32'(dv_cnt), 32'(base + 2));
    check_frame("b2b0", base, 8'h01, 1'b0, 1'b0);
    check_frame("b2b1", base + 1, 8'h80, 1'b0, 1'b0);
    check_eq("b2b_gap", 32'(dv_cyc[(base + 1) % 64] - dv_cyc[base % 64]), 32'd80);

    // reset for one clock during data bit 3 of 0x3C
    base = dv_cnt;
    rx_if.serial_data_in = 1'b0;
    idle(8);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    rx_if.serial_data_in = 1'b1;
    idle(4);
    check_eq("mid_busy", 32'(rx_if.busy), 32'd1);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    check_eq("abort_busy", 32'(rx_if.busy), 32'd0);
    check_eq("abort_data", 32'(rx_if.parallel_data), 32'd0);
    check_eq("abort_dv",   32'(rx_if.data_valid), 32'd0);
    check_eq("abort_perr", 32'(rx_if.parity_error), 32'd0);
    check_eq("abort_ferr", 32'(rx_if.framing_error), 32'd0);
    idle(100);
    check_eq("abort_no_dv", 32'(dv_cnt), 32'(base));
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, c0);
    wait_dv("3c_dv", base + 1);
    idle(16);
    check_frame("3c", base, 8'h3C, 1'b0, 1'b0);
    check_eq("3c_latency", 32'(dv_cyc[base % 64]), 32'(c0 + SYNC + LAT_NP));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
